// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// controller : 16 x 256-bit register-file controller, one instruction per clock
// Optional CTRL_ZEROIZE_EN enables op 6 (wipe all registers). Rev 1.0
// ============================================================================
module controller #(
  parameter int NREGS = 16,
  parameter int DW    = 256
) (
  input  logic             clock,
  input  logic [DW+10:0]   instruct,
  output logic [DW-1:0]    out,
  input  logic             reset_n
);

  localparam logic [5:0] c_op_load = 6'd0;
  localparam logic [5:0] c_op_xor  = 6'd1;
  localparam logic [5:0] c_op_add  = 6'd2;
  localparam logic [5:0] c_op_rotl = 6'd3;
  localparam logic [5:0] c_op_and  = 6'd4;
  localparam logic [5:0] c_op_zero = 6'd6;

  logic [DW-1:0]   regs [NREGS];

  logic [5:0]      w_op;
  logic            w_we;
  logic [3:0]      w_addr;
  logic [DW-1:0]   w_data;
  logic [DW-1:0]   w_a;
  logic [2*DW-1:0] w_dbl;
  logic [DW-1:0]   w_result;
  logic            w_valid;
  logic            w_zeroize;

  assign w_op   = instruct[DW+10:DW+5];
  assign w_we   = instruct[DW+4];
  assign w_addr = instruct[DW+3:DW];
  assign w_data = instruct[DW-1:0];
  assign w_a    = regs[w_addr];

  // Rotating the doubled word keeps amount 0 well defined (upper half = A).
  assign w_dbl  = {w_a, w_a} << w_data[7:0];

  always_comb begin
    w_result  = '0;
    w_valid   = 1'b0;
    w_zeroize = 1'b0;
    case (w_op)
      c_op_load: begin
        w_result = w_we ? w_data : w_a;
        w_valid  = 1'b1;
      end
      c_op_xor: begin
        w_result = w_a ^ w_data;
        w_valid  = 1'b1;
      end
      c_op_add: begin
        w_result = w_a + w_data;
        w_valid  = 1'b1;
      end
      c_op_rotl: begin
        w_result = w_dbl[2*DW-1:DW];
        w_valid  = 1'b1;
      end
      c_op_and: begin
        w_result = w_a & w_data;
        w_valid  = 1'b1;
      end
`ifdef CTRL_ZEROIZE_EN
      c_op_zero: begin
        w_zeroize = 1'b1;
      end
`else
      c_op_zero: begin
        w_zeroize = 1'b0;
      end
`endif
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      out <= '0;
    end else if (w_zeroize) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      out <= '0;
    end else if (w_valid) begin
      out <= w_result;
      if (w_we) begin
        regs[w_addr] <= w_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// Directed, table-driven bench for controller.
module tb_controller;

  logic         clock;
  logic         reset_n;
  logic [266:0] instruct;
  logic [255:0] out;

  int nvec;
  int nfail;

  typedef struct {
    logic [5:0]   op;
    logic         we;
    logic [3:0]   addr;
    logic [255:0] data;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [255:0] c_ones = {256{1'b1}};
  localparam logic [255:0] c_msb  = {1'b1, 255'b0};

  controller #(.NREGS(16), .DW(256)) dut (
    .clock    (clock),
    .instruct (instruct),
    .out      (out),
    .reset_n  (reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic [5:0] op, input logic we, input logic [3:0] addr,
                     input logic [255:0] data, input logic [255:0] exp);
    vec_t v;
    v.op = op; v.we = we; v.addr = addr; v.data = data; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [255:0] exp);
    nvec++;
    if (out !== exp) begin
      nfail++;
      $display("FAIL %s: out=%h expected=%h", name, out, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic [5:0] op, input logic we, input logic [3:0] addr,
                       input logic [255:0] data, input logic [255:0] exp, input string name);
    @(negedge clock);
    instruct = {op, we, addr, data};
    @(posedge clock);
    #1;
    check(name, exp);
  endtask

  initial begin
    nvec     = 0;
    nfail    = 0;
    reset_n  = 1'b0;
    instruct = '0;

    for (int i = 0; i < 16; i++) add(6'd0, 1'b0, 4'(i), 256'd0, 256'd0);
    add(6'd0,  1'b1, 4'd8,  256'd12,    256'd12);
    add(6'd0,  1'b1, 4'd10, 256'd4,     256'd4);
    add(6'd0,  1'b0, 4'd9,  256'd0,     256'd0);
    add(6'd0,  1'b0, 4'd8,  256'd0,     256'd12);
    add(6'd0,  1'b1, 4'd3,  256'hFF,    256'hFF);
    add(6'd1,  1'b1, 4'd3,  256'h0F,    256'hF0);
    add(6'd2,  1'b1, 4'd3,  256'h10,    256'h100);
    add(6'd0,  1'b1, 4'd5,  c_ones,     c_ones);
    add(6'd2,  1'b1, 4'd5,  256'd1,     256'd0);
    add(6'd0,  1'b0, 4'd5,  256'd0,     256'd0);
    add(6'd0,  1'b1, 4'd2,  c_msb,      c_msb);
    add(6'd3,  1'b0, 4'd2,  256'd1,     256'd1);
    add(6'd3,  1'b0, 4'd2,  256'h100,   c_msb);
    add(6'd3,  1'b0, 4'd2,  256'h04,    256'h8);
    add(6'd4,  1'b1, 4'd3,  256'h1F0,   256'h100);
    add(6'd1,  1'b1, 4'd3,  256'h100,   256'h0);
    add(6'd1,  1'b1, 4'd3,  256'h100,   256'h100);
    add(6'd9,  1'b1, 4'd8,  c_ones,     256'h100);
    add(6'd0,  1'b0, 4'd8,  256'd0,     256'd12);
    add(6'd5,  1'b1, 4'd8,  256'd0,     256'd12);
    add(6'd0,  1'b0, 4'd8,  256'd0,     256'd12);
    add(6'd63, 1'b1, 4'd10, c_ones,     256'd12);
    add(6'd0,  1'b0, 4'd10, 256'd0,     256'd4);
    add(6'd0,  1'b0, 4'd3,  256'd0,     256'h100);

    #12;
    check("reset_out", 256'd0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

`ifdef CTRL_ZEROIZE_EN
    apply(6'd6, 1'b0, 4'd7, c_ones, 256'd0,   "zeroize_out");
    apply(6'd0, 1'b0, 4'd8, 256'd0, 256'd0,   "zeroize_r8");
    apply(6'd0, 1'b0, 4'd10, 256'd0, 256'd0,  "zeroize_r10");
    apply(6'd0, 1'b0, 4'd3, 256'd0, 256'd0,   "zeroize_r3");
`else
    apply(6'd6, 1'b1, 4'd8, c_ones, 256'h100, "op6_nop_out");
    apply(6'd0, 1'b0, 4'd8, 256'd0, 256'd12,  "op6_nop_r8");
    apply(6'd0, 1'b0, 4'd10, 256'd0, 256'd4,  "op6_nop_r10");
    apply(6'd0, 1'b0, 4'd3, 256'd0, 256'h100, "op6_nop_r3");
`endif

    // Asynchronous mid-cycle reset clears state without a clock edge.
    apply(6'd0, 1'b1, 4'd1, 256'd7, 256'd7, "pre_reset_load");
    @(negedge clock);
    instruct = {6'd9, 1'b0, 4'd1, 256'd0};
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out", 256'd0);
    @(negedge clock);
    reset_n = 1'b1;
    apply(6'd0, 1'b0, 4'd1, 256'd0, 256'd0, "post_reset_r1");
    apply(6'd0, 1'b0, 4'd10, 256'd0, 256'd0, "post_reset_r10");
    apply(6'd0, 1'b1, 4'd4, 256'h55, 256'h55, "post_reset_load");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controller.md
Name: controller

Overview:
- Instruction-driven register-file controller for the crypto coprocessor datapath.
- Holds sixteen 256-bit working registers.
- Each clock it decodes one 267-bit instruction word and applies one of: load, read, XOR, add, rotate-left, AND.
- It optionally writes the result back and always presents the result on a registered 256-bit output.

Parameters:
- NREGS, 16, number of working registers (address field is 4 bits; fixed at 16).
- DW, 256, datapath/register width in bits.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- instruct  input  267  instruction word, sampled every rising edge.
- out  output  256  registered result.
- Declaration order is clock, instruct, out, reset_n, so positional instantiation (clock, instruct, out) remains valid.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (reset_n).
- On reset:
  - All 16 registers = 0.
  - out = 0.
- Instruction fields:
  - op = instruct[266:261] (6 bits).
  - we = instruct[260], write-back enable.
  - addr = instruct[259:256], register index 0..15.
  - data = instruct[255:0], immediate operand.
- Every rising edge with reset_n=1, compute result R from A = reg[addr] (value before the edge) and data, per op:
  - 0 LOAD/READ: if we=1, R = data; if we=0, R = A.
  - 1 XOR: R = A ^ data.
  - 2 ADD: R = (A + data) mod 2^256; carry discarded.
  - 3 ROTL: R = A rotated left by data[7:0] bit positions. Amount 0 gives R = A. data[255:8] ignored.
  - 4 AND: R = A & data.
  - 5: reserved, treated as NOP.
  - 6: ZEROIZE, see Optional Feature.
  - 7..63: NOP. No register write; out holds its previous value.
- For ops 0..4:
  - out <= R on the same edge (1-cycle latency from instruction sample to out).
  - If we=1, reg[addr] <= R on the same edge. If we=0, the register file is unchanged.
- No handshake. An instruction is consumed every cycle; holding the instruction constant re-executes it each cycle. Example: XOR with we=1 held for two cycles toggles the register back.
- Back-to-back instructions to the same addr see the value written by the previous cycle; there is no forwarding hazard.
- Only the addressed register changes; the other 15 are untouched.
- reset_n asserted mid-stream clears all state immediately, regardless of clock. The first edge after deassertion executes normally.
- X or unknown op bits are not decoded specially; any non-defined code behaves as NOP.

Optional Feature:
- Macro CTRL_ZEROIZE_EN.
- Defined:
  - op 6 (ZEROIZE) clears all 16 registers to 0 and sets out <= 0 in one cycle, regardless of we and addr (key-material wipe).
- Not defined:
  - op 6 is a NOP like 7..63.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> out=0 immediately. Then op0/we=0 on each of addr 0..15 -> out=0 for each.
- Load/read: op0, we=1, addr=8, data=12; next cycle op0, we=1, addr=10, data=4; then op0, we=0, addr=9 -> out=12, then 4, then 0. Follow with op0, we=0, addr=8 -> out=12.
- XOR/ADD with write-back: reg3=0xFF; op1, we=1, data=0x0F -> out=0xF0. Then op2, we=1, data=0x10 -> out=0x100.
- ADD wrap: reg5 = 2^256-1; op2, we=1, data=1 -> out=0 and reg5=0.
- ROTL: reg2 = 1<<255; op3, we=0, data=1 -> out=1 and reg2 unchanged. Then data=0x100 (amount 0) -> out=1<<255.
- NOP and zeroize: op9 with any fields -> out holds and no register changes. With CTRL_ZEROIZE_EN: op6 -> out=0 and every subsequent read returns 0. Without the macro: op6 -> registers preserved.
